// File: rtl/sram_port_arbiter_if.sv
// Bus bundle between the IF/MEM requesters, the arbiter and the SRAM controller.
// slave = arbiter view; master = requesters plus SRAM controller (the arbiter's environment).
interface sram_port_arbiter_if #(
    parameter int ADDRESS_LEN = 32,
    parameter int WORD_LEN    = 32
);
    logic                   if_rd_en;
    logic [ADDRESS_LEN-1:0] if_address;
    logic [WORD_LEN-1:0]    if_rdata;
    logic                   if_ready;

    logic                   mem_rd_en;
    logic                   mem_wr_en;
    logic [ADDRESS_LEN-1:0] mem_address;
    logic [WORD_LEN-1:0]    mem_wdata;
    logic [WORD_LEN-1:0]    mem_rdata;
    logic                   mem_ready;

    logic                   sram_read_en;
    logic                   sram_write_en;
    logic [ADDRESS_LEN-1:0] sram_address;
    logic [WORD_LEN-1:0]    sram_write_data;
    logic [WORD_LEN-1:0]    sram_read_data;
    logic                   sram_ready;

    modport slave (
        input  if_rd_en, if_address, mem_rd_en, mem_wr_en, mem_address, mem_wdata,
        input  sram_read_data, sram_ready,
        output if_rdata, if_ready, mem_rdata, mem_ready,
        output sram_read_en, sram_write_en, sram_address, sram_write_data
    );

    modport master (
        output if_rd_en, if_address, mem_rd_en, mem_wr_en, mem_address, mem_wdata,
        output sram_read_data, sram_ready,
        input  if_rdata, if_ready, mem_rdata, mem_ready,
        input  sram_read_en, sram_write_en, sram_address, sram_write_data
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM controller port between instruction fetch and the data port, with watchdog abort.
// Define ARB_ROUND_ROBIN_EN to alternate grants on simultaneous requests (default: MEM beats IF).
module sram_port_arbiter #(
    parameter int                  ADDRESS_LEN = 32,
    parameter int                  WORD_LEN    = 32,
    parameter int                  TIMEOUT_CYC = 255,
    parameter logic [WORD_LEN-1:0] ABORT_DATA  = 32'hDEAD_BEEF
) (
    input  logic                    clk,
    input  logic                    rst,
    sram_port_arbiter_if.slave      bus,
    output logic                    timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    localparam logic GRANT_IF  = 1'b0;
    localparam logic GRANT_MEM = 1'b1;
    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT_CYC - 1);

    state_t                 state_r,        state_nxt_s;
    logic                   grant_r,        grant_nxt_s;
    logic                   last_grant_r,   last_grant_nxt_s;
    logic                   read_en_r,      read_en_nxt_s;
    logic                   write_en_r,     write_en_nxt_s;
    logic [ADDRESS_LEN-1:0] address_r,      address_nxt_s;
    logic [WORD_LEN-1:0]    wdata_r,        wdata_nxt_s;
    logic [WORD_LEN-1:0]    if_rdata_r,     if_rdata_nxt_s;
    logic [WORD_LEN-1:0]    mem_rdata_r,    mem_rdata_nxt_s;
    logic [7:0]             wdog_r,         wdog_nxt_s;
    logic                   timeout_err_r,  timeout_err_nxt_s;

    logic req_if_s;
    logic req_mem_s;
    logic win_s;

    assign req_if_s  = bus.if_rd_en;
    assign req_mem_s = bus.mem_rd_en | bus.mem_wr_en;

    // Next-state, arbitration and datapath capture for the request FSM.
    always_comb begin
        state_nxt_s       = state_r;
        grant_nxt_s       = grant_r;
        last_grant_nxt_s  = last_grant_r;
        read_en_nxt_s     = read_en_r;
        write_en_nxt_s    = write_en_r;
        address_nxt_s     = address_r;
        wdata_nxt_s       = wdata_r;
        if_rdata_nxt_s    = if_rdata_r;
        mem_rdata_nxt_s   = mem_rdata_r;
        wdog_nxt_s        = wdog_r;
        timeout_err_nxt_s = timeout_err_r;

`ifdef ARB_ROUND_ROBIN_EN
        if (req_if_s && req_mem_s) begin
            win_s = ~last_grant_r;
        end else begin
            win_s = req_mem_s ? GRANT_MEM : GRANT_IF;
        end
`else
        win_s = req_mem_s ? GRANT_MEM : GRANT_IF;
`endif

        case (state_r)
            ST_IDLE: begin
                if (req_if_s || req_mem_s) begin
                    grant_nxt_s = win_s;
                    wdog_nxt_s  = 8'd0;
                    state_nxt_s = ST_BUSY;
                    if (win_s == GRANT_MEM) begin
                        address_nxt_s = bus.mem_address;
                        // A combined read+write request is served as a write only.
                        if (bus.mem_wr_en) begin
                            write_en_nxt_s = 1'b1;
                            read_en_nxt_s  = 1'b0;
                            wdata_nxt_s    = bus.mem_wdata;
                        end else begin
                            write_en_nxt_s = 1'b0;
                            read_en_nxt_s  = 1'b1;
                        end
                    end else begin
                        address_nxt_s  = bus.if_address;
                        write_en_nxt_s = 1'b0;
                        read_en_nxt_s  = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end

            ST_BUSY: begin
                // wdog==0 marks the first BUSY cycle, where sram_ready is still stale.
                if ((wdog_r != 8'd0) && bus.sram_ready) begin
                    if (read_en_r) begin
                        if (grant_r == GRANT_MEM) begin
                            mem_rdata_nxt_s = bus.sram_read_data;
                        end else begin
                            if_rdata_nxt_s = bus.sram_read_data;
                        end
                    end else begin
                        mem_rdata_nxt_s = mem_rdata_r;
                    end
                    read_en_nxt_s  = 1'b0;
                    write_en_nxt_s = 1'b0;
                    state_nxt_s    = ST_RESP;
                end else if (wdog_r >= WDOG_LAST) begin
                    if (grant_r == GRANT_MEM) begin
                        mem_rdata_nxt_s = ABORT_DATA;
                    end else begin
                        if_rdata_nxt_s = ABORT_DATA;
                    end
                    timeout_err_nxt_s = 1'b1;
                    read_en_nxt_s     = 1'b0;
                    write_en_nxt_s    = 1'b0;
                    state_nxt_s       = ST_RESP;
                end else begin
                    wdog_nxt_s = wdog_r + 8'd1;
                end
            end

            ST_RESP: begin
                last_grant_nxt_s = grant_r;
                state_nxt_s      = ST_IDLE;
            end

            default: begin
                read_en_nxt_s  = 1'b0;
                write_en_nxt_s = 1'b0;
                state_nxt_s    = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            grant_r       <= GRANT_MEM;
            last_grant_r  <= GRANT_MEM;
            read_en_r     <= 1'b0;
            write_en_r    <= 1'b0;
            address_r     <= '0;
            wdata_r       <= '0;
            if_rdata_r    <= '0;
            mem_rdata_r   <= '0;
            wdog_r        <= 8'd0;
            timeout_err_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            grant_r       <= grant_nxt_s;
            last_grant_r  <= last_grant_nxt_s;
            read_en_r     <= read_en_nxt_s;
            write_en_r    <= write_en_nxt_s;
            address_r     <= address_nxt_s;
            wdata_r       <= wdata_nxt_s;
            if_rdata_r    <= if_rdata_nxt_s;
            mem_rdata_r   <= mem_rdata_nxt_s;
            wdog_r        <= wdog_nxt_s;
            timeout_err_r <= timeout_err_nxt_s;
        end
    end

    assign bus.sram_read_en    = read_en_r;
    assign bus.sram_write_en   = write_en_r;
    assign bus.sram_address    = address_r;
    assign bus.sram_write_data = wdata_r;
    assign bus.if_rdata        = if_rdata_r;
    assign bus.mem_rdata       = mem_rdata_r;
    assign timeout_err         = timeout_err_r;

    // A port is frozen while it requests, except in its own response cycle.
    assign bus.if_ready  = ~req_if_s  | ((state_r == ST_RESP) & (grant_r == GRANT_IF));
    assign bus.mem_ready = ~req_mem_s | ((state_r == ST_RESP) & (grant_r == GRANT_MEM));

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed cases plus randomized traffic
// compared every cycle against a transaction-timeline model.
module tb_sram_port_arbiter;

    localparam int          TO    = 255;
    localparam logic [31:0] ABORT = 32'hDEAD_BEEF;

    logic clk;
    logic rst;
    logic timeout_err;

    sram_port_arbiter_if #(.ADDRESS_LEN(32), .WORD_LEN(32)) bus ();

    sram_port_arbiter #(
        .ADDRESS_LEN(32), .WORD_LEN(32), .TIMEOUT_CYC(TO), .ABORT_DATA(ABORT)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .timeout_err(timeout_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1);
    end

    // SRAM controller stand-in: 0 random, 1 ready on k-th enable cycle, 2 never, 3 always.
    int          resp_mode = 1;
    int          k_lat     = 3;
    int          en_cnt    = 0;
    logic [31:0] rd_val    = 32'h0;

    initial begin
        bus.sram_ready     = 1'b0;
        bus.sram_read_data = 32'h0;
        forever begin
            @(posedge clk); #2;
            if (bus.sram_read_en || bus.sram_write_en) en_cnt++; else en_cnt = 0;
            case (resp_mode)
                0: begin
                    bus.sram_ready     = ($urandom_range(0, 3) == 0);
                    bus.sram_read_data = $urandom;
                end
                1: begin
                    bus.sram_ready     = (en_cnt == k_lat);
                    bus.sram_read_data = rd_val;
                end
                2: begin
                    bus.sram_ready     = 1'b0;
                    bus.sram_read_data = rd_val;
                end
                default: begin
                    bus.sram_ready     = 1'b1;
                    bus.sram_read_data = rd_val;
                end
            endcase
        end
    end

    // Model: one transaction at a time on a cycle timeline. Decision cycle s, enables
    // from s+1 until completion cycle e, response at e+1, next decision no earlier than e+2.
    bit          chk_en = 1'b0;
    int          cyc    = 0;
    bit          m_active = 1'b0;
    int          m_start  = 0;
    int          m_end    = -1;
    bit          m_port   = 1'b1;   // 1 = MEM, 0 = IF
    bit          m_write  = 1'b0;
    bit          m_last   = 1'b1;
    bit          m_terr   = 1'b0;
    logic [31:0] m_addr   = 32'h0;
    logic [31:0] m_wdata  = 32'h0;
    logic [31:0] m_if_rd  = 32'h0;
    logic [31:0] m_mem_rd = 32'h0;

    initial begin : compare
        bit en_exp, resp_exp, req_if, req_mem, w;
        int el;
        forever begin
            @(negedge clk);
            req_if   = bus.if_rd_en;
            req_mem  = bus.mem_rd_en | bus.mem_wr_en;
            en_exp   = m_active && (cyc > m_start) && (m_end < 0);
            resp_exp = m_active && (m_end >= 0) && (cyc == m_end + 1);
            if (chk_en) begin
                check("sram_read_en",  bus.sram_read_en,  en_exp && !m_write);
                check("sram_write_en", bus.sram_write_en, en_exp && m_write);
                check("if_ready",      bus.if_ready,  !req_if  || (resp_exp && !m_port));
                check("mem_ready",     bus.mem_ready, !req_mem || (resp_exp && m_port));
                check("if_rdata",      bus.if_rdata,  m_if_rd);
                check("mem_rdata",     bus.mem_rdata, m_mem_rd);
                check("timeout_err",   timeout_err,   m_terr);
                if (en_exp) begin
                    check("sram_address", bus.sram_address, m_addr);
                    if (m_write) check("sram_write_data", bus.sram_write_data, m_wdata);
                end
            end
            if (!rst) begin
                m_active = 1'b0; m_end = -1; m_last = 1'b1; m_terr = 1'b0;
                m_if_rd = 32'h0; m_mem_rd = 32'h0;
            end else if (m_active) begin
                if (m_end < 0) begin
                    el = cyc - m_start;
                    if (el >= 2 && bus.sram_ready) begin
                        m_end = cyc;
                        if (!m_write) begin
                            if (m_port) m_mem_rd = bus.sram_read_data;
                            else        m_if_rd  = bus.sram_read_data;
                        end
                    end else if (el >= TO) begin
                        m_end  = cyc;
                        m_terr = 1'b1;
                        if (m_port) m_mem_rd = ABORT;
                        else        m_if_rd  = ABORT;
                    end
                end else if (cyc == m_end + 1) begin
                    m_last   = m_port;
                    m_active = 1'b0;
                end
            end else if (req_if || req_mem) begin
`ifdef ARB_ROUND_ROBIN_EN
                w = (req_if && req_mem) ? !m_last : req_mem;
`else
                w = req_mem;
`endif
                m_active = 1'b1;
                m_start  = cyc;
                m_end    = -1;
                m_port   = w;
                m_write  = w && bus.mem_wr_en;
                m_addr   = w ? bus.mem_address : bus.if_address;
                m_wdata  = bus.mem_wdata;
            end
            cyc++;
        end
    end

    typedef struct {
        int rd_c; int wr_c; int if_n; int mem_n; int if_t; int mem_t;
        logic [31:0] if_d; logic [31:0] mem_d; logic [31:0] addr; logic [31:0] wdata;
    } res_t;

    // Holds requests until each port sees its ready pulse; t=0 is the call cycle.
    task automatic serve(input string nm, input int budget, output res_t r);
        bit drop_if, drop_mem;
        r = '{0, 0, 0, 0, -1, -1, 32'h0, 32'h0, 32'h0, 32'h0};
        for (int t = 0; t < budget && (bus.if_rd_en || bus.mem_rd_en || bus.mem_wr_en); t++) begin
            @(negedge clk);
            drop_if = 1'b0; drop_mem = 1'b0;
            if (bus.sram_read_en) begin r.rd_c++; r.addr = bus.sram_address; end
            if (bus.sram_write_en) begin
                r.wr_c++; r.addr = bus.sram_address; r.wdata = bus.sram_write_data;
            end
            if (bus.if_rd_en && bus.if_ready) begin
                r.if_n++; r.if_t = t; r.if_d = bus.if_rdata; drop_if = 1'b1;
            end
            if ((bus.mem_rd_en || bus.mem_wr_en) && bus.mem_ready) begin
                r.mem_n++; r.mem_t = t; r.mem_d = bus.mem_rdata; drop_mem = 1'b1;
            end
            @(posedge clk); #1;
            if (drop_if) bus.if_rd_en = 1'b0;
            if (drop_mem) begin bus.mem_rd_en = 1'b0; bus.mem_wr_en = 1'b0; end
        end
        check({"serve_budget_", nm}, {63'h0, bus.if_rd_en | bus.mem_rd_en | bus.mem_wr_en}, 64'h0);
    endtask

    initial begin : main
        res_t r;
        bit   if_acc, mem_acc;
        int   op;
        rst = 1'b0;
        bus.if_rd_en = 1'b0; bus.if_address = 32'h0;
        bus.mem_rd_en = 1'b0; bus.mem_wr_en = 1'b0;
        bus.mem_address = 32'h0; bus.mem_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1; rst = 1'b1; chk_en = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_read_en",   bus.sram_read_en,    0);
        check("rst_write_en",  bus.sram_write_en,   0);
        check("rst_address",   bus.sram_address,    0);
        check("rst_wdata",     bus.sram_write_data, 0);
        check("rst_if_rdata",  bus.if_rdata,        0);
        check("rst_mem_rdata", bus.mem_rdata,       0);
        check("rst_terr",      timeout_err,         0);
        check("rst_if_ready",  bus.if_ready,        1);
        check("rst_mem_ready", bus.mem_ready,       1);
        @(posedge clk); #1;

        // IF read, SRAM completes on the 3rd enable cycle
        resp_mode = 1; k_lat = 3; rd_val = 32'h1234_5678;
        bus.if_rd_en = 1'b1; bus.if_address = 32'h40;
        serve("if_read", 40, r);
        check("if_read_rd_cycles", r.rd_c, 3);
        check("if_read_pulses",    r.if_n, 1);
        check("if_read_latency",   r.if_t, 4);
        check("if_read_data",      r.if_d, 32'h1234_5678);
        check("if_read_addr",      r.addr, 32'h40);

        // MEM write
        k_lat = 2;
        bus.mem_wr_en = 1'b1; bus.mem_address = 32'h100; bus.mem_wdata = 32'hCAFE_0001;
        serve("mem_write", 40, r);
        check("mem_write_wr_cycles", r.wr_c,  2);
        check("mem_write_rd_cycles", r.rd_c,  0);
        check("mem_write_addr",      r.addr,  32'h100);
        check("mem_write_wdata",     r.wdata, 32'hCAFE_0001);
        check("mem_write_latency",   r.mem_t, 3);
        check("mem_write_rdata",     r.mem_d, 32'h0);

        // Simultaneous IF and MEM reads (last grant was MEM)
        rd_val = 32'h0BAD_F00D;
        bus.if_rd_en = 1'b1; bus.if_address = 32'h200;
        bus.mem_rd_en = 1'b1; bus.mem_address = 32'h300;
        serve("both", 60, r);
`ifdef ARB_ROUND_ROBIN_EN
        check("both_if_t",  r.if_t,  3);
        check("both_mem_t", r.mem_t, 7);
`else
        check("both_mem_t", r.mem_t, 3);
        check("both_if_t",  r.if_t,  7);
`endif
        check("both_rd_cycles", r.rd_c,  4);
        check("both_if_data",   r.if_d,  32'h0BAD_F00D);
        check("both_mem_data",  r.mem_d, 32'h0BAD_F00D);

        // Watchdog abort, then a good transaction keeps timeout_err set
        resp_mode = 2;
        bus.mem_rd_en = 1'b1; bus.mem_address = 32'h500;
        serve("timeout", 400, r);
        check("timeout_latency",   r.mem_t, 256);
        check("timeout_rd_cycles", r.rd_c,  255);
        check("timeout_data",      r.mem_d, 32'hDEAD_BEEF);
        @(negedge clk);
        check("timeout_err_set", timeout_err, 1);
        @(posedge clk); #1;
        resp_mode = 1; k_lat = 2; rd_val = 32'h5555_AAAA;
        bus.if_rd_en = 1'b1; bus.if_address = 32'h44;
        serve("after_timeout", 40, r);
        check("after_timeout_data",    r.if_d, 32'h5555_AAAA);
        check("after_timeout_latency", r.if_t, 3);
        @(negedge clk);
        check("timeout_err_sticky", timeout_err, 1);
        @(posedge clk); #1;

        // Reset during BUSY, request held across it
        resp_mode = 2;
        bus.mem_rd_en = 1'b1; bus.mem_address = 32'h600;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("busy_before_rst", bus.sram_read_en, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_read_en",   bus.sram_read_en, 0);
        check("rst_mid_terr",      timeout_err,      0);
        check("rst_mid_mem_ready", bus.mem_ready,    0);
        @(posedge clk); #1;
        @(negedge clk);
        check("regrant_read_en", bus.sram_read_en, 1);
        resp_mode = 1; k_lat = 2; rd_val = 32'h3C3C_0006;
        @(posedge clk); #1;
        serve("regrant", 40, r);
        check("regrant_latency", r.mem_t, 1);
        check("regrant_data",    r.mem_d, 32'h3C3C_0006);

        // Read+write together -> write only; ready held high from the start
        resp_mode = 3;
        bus.mem_rd_en = 1'b1; bus.mem_wr_en = 1'b1;
        bus.mem_address = 32'h700; bus.mem_wdata = 32'h7777_0007;
        serve("rdwr", 40, r);
        check("rdwr_wr_cycles", r.wr_c,  2);
        check("rdwr_rd_cycles", r.rd_c,  0);
        check("rdwr_latency",   r.mem_t, 3);
        check("rdwr_wdata",     r.wdata, 32'h7777_0007);
        check("rdwr_rdata",     r.mem_d, 32'h3C3C_0006);

        // Randomized traffic; the compare process checks every cycle
        resp_mode = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if_acc  = bus.if_rd_en && bus.if_ready;
            mem_acc = (bus.mem_rd_en || bus.mem_wr_en) && bus.mem_ready;
            @(posedge clk); #1;
            if (bus.if_rd_en) begin
                if (if_acc || $urandom_range(0, 63) == 0) begin
                    if ($urandom_range(0, 3) == 0) bus.if_address = $urandom;
                    else bus.if_rd_en = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                bus.if_rd_en = 1'b1; bus.if_address = $urandom;
            end
            if (bus.mem_rd_en || bus.mem_wr_en) begin
                if (mem_acc || $urandom_range(0, 63) == 0) begin
                    bus.mem_rd_en = 1'b0; bus.mem_wr_en = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                op = $urandom_range(0, 3);
                bus.mem_rd_en   = (op != 2);
                bus.mem_wr_en   = (op >= 2);
                bus.mem_address = $urandom;
                bus.mem_wdata   = $urandom;
            end
        end
        bus.if_rd_en = 1'b0; bus.mem_rd_en = 1'b0; bus.mem_wr_en = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
